// File: rtl/dispatch_pkg.sv
// Shared types and default parameters for the one-hot dispatcher.
package dispatch_pkg;

  localparam int unsigned DEFAULT_N       = 4;
  localparam int unsigned DEFAULT_TIMEOUT = 16;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/priority_encoder.sv
// Combinational priority encoder: index of the highest set request bit.
module priority_encoder #(
  parameter int unsigned N = 4
) (
  input  logic [2**N-1:0] req,
  output logic [N-1:0]    idx,
  output logic            valid
);

  localparam int unsigned L = 2**N;

  // Later (higher) bits overwrite earlier ones, so the highest wins.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < int'(L); i++) begin
      if (req[i]) begin
        idx   = N'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/onehot_dispatcher.sv
// Queues line requests and issues them one at a time, highest index first,
// holding each issue until acked or until the wait timer expires.
module onehot_dispatcher
  import dispatch_pkg::*;
#(
  parameter int unsigned N       = DEFAULT_N,
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    idx_in,
  input  logic            idx_valid,
  input  logic [2**N-1:0] line_ack,
  output logic [2**N-1:0] line_out,
  output logic [2**N-1:0] pending,
  output logic            busy,
  output logic            dup,
  output logic            timeout_err
);

  localparam int unsigned L  = 2**N;
  localparam int unsigned TW = $clog2(TIMEOUT);

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [L-1:0]    line_d, pend_d, pend_clr, pend_set;
  logic            dup_d, tmo_d;
  logic [N-1:0]    pe_idx;
  logic            pe_valid;

  priority_encoder #(.N(N)) u_pe (
    .req   (pending),
    .idx   (pe_idx),
    .valid (pe_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      line_out    <= '0;
      pending     <= '0;
      dup         <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      line_out    <= line_d;
      pending     <= pend_d;
      dup         <= dup_d;
      timeout_err <= tmo_d;
    end
  end

  // Next-state, issue/clear decisions and pending update (set beats clear).
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    line_d   = line_out;
    pend_clr = '0;
    tmo_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pe_valid) begin
          state_d  = WAIT;
          line_d   = L'(1) << pe_idx;
          pend_clr = L'(1) << pe_idx;
          timer_d  = '0;
        end
      end
      WAIT: begin
        timer_d = timer_q + TW'(1);
        if ((line_ack & line_out) != '0) begin
          line_d  = '0;
          state_d = IDLE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          line_d  = '0;
          tmo_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        line_d  = '0;
      end
    endcase
    pend_set = idx_valid ? (L'(1) << idx_in) : '0;
    pend_d   = (pending & ~pend_clr) | pend_set;
    dup_d    = idx_valid && pending[idx_in];
  end

  assign busy = (state_q == WAIT);

endmodule
